// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  // Width of the fetch starvation counter; STARVE_MAX must fit in it.
  localparam int STARVE_W = 4;

  // Arbiter FSM: idle, or waiting for the response of the one outstanding access.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } arb_state_t;

  // Owner of the request presented to memory in IDLE.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_starve.sv
// Saturating count of IDLE arbitrations lost by a pending fetch to data.
// Latency: count updates on the clock after inc/clr; sat is combinational from the count.
// Backpressure: none; holds its value on any cycle without inc or clr.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] r_cnt;

  // Clear on a fetch grant, otherwise count data wins up to the saturation limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_C)) begin
      r_cnt <= r_cnt + STARVE_W'(1);
    end
  end

  assign o_sat = (r_cnt == MAX_C);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data, one access in flight.
// Latency: grant is combinational with m_gnt; response routed combinationally from m_rvalid; 2-cycle issue spacing.
// Backpressure: without m_gnt the selected request stays on m_* and the requester holds; starvation guard forces fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  input  logic              i_kill,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [XLEN-1:0]   m_addr,
  output logic [XLEN-1:0]   m_wdata,
  output logic [XLEN/8-1:0] m_be,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [XLEN-1:0]   m_rdata,
  output logic              err
);

  arb_state_t r_state, w_state_nxt;
  arb_owner_t w_owner;
  logic       r_kill_pend;
  logic       r_err;
  logic       w_sat;
  logic       w_sel_any;
  logic       w_m_req, w_m_we;
  logic [XLEN-1:0]   w_m_addr, w_m_wdata;
  logic [XLEN/8-1:0] w_m_be;
  logic       w_i_gnt, w_d_gnt, w_i_rvalid, w_d_rvalid;

  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .reset_n(reset_n),
    .i_inc  ((r_state == IDLE) && i_req && w_d_gnt),
    .i_clr  (w_i_gnt),
    .o_sat  (w_sat)
  );

  // Pick the IDLE owner: a starved fetch wins, otherwise data beats fetch.
  always_comb begin
    w_owner   = OWN_D;
    w_sel_any = 1'b0;
    if (i_req && (w_sat || !d_req)) begin
      w_owner   = OWN_I;
      w_sel_any = 1'b1;
    end else if (d_req) begin
      w_owner   = OWN_D;
      w_sel_any = 1'b1;
    end
  end

  // Next state, memory request mux, grants and response routing.
  always_comb begin
    w_state_nxt = r_state;
    w_m_req     = 1'b0;
    w_m_we      = 1'b0;
    w_m_addr    = '0;
    w_m_wdata   = '0;
    w_m_be      = '0;
    w_i_gnt     = 1'b0;
    w_d_gnt     = 1'b0;
    w_i_rvalid  = 1'b0;
    w_d_rvalid  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_sel_any) begin
          w_m_req = 1'b1;
          if (w_owner == OWN_I) begin
            w_m_addr = i_addr;
            w_m_be   = '1;
            w_i_gnt  = m_gnt;
            if (m_gnt) w_state_nxt = WAIT_I;
          end else begin
            w_m_we    = d_we;
            w_m_addr  = d_addr;
            w_m_wdata = d_wdata;
            w_m_be    = d_be;
            w_d_gnt   = m_gnt;
            if (m_gnt) w_state_nxt = WAIT_D;
          end
        end
      end
      WAIT_I: begin
        if (m_rvalid) begin
          // A flush seen at any point of the wait, including now, drops the fetch data.
          w_i_rvalid  = !(r_kill_pend || i_kill);
          w_state_nxt = IDLE;
        end
      end
      WAIT_D: begin
        if (m_rvalid) begin
          w_d_rvalid  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Remember a flush during WAIT_I until the fetch response retires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kill_pend <= 1'b0;
    end else if ((r_state == WAIT_I) && !m_rvalid) begin
      r_kill_pend <= r_kill_pend | i_kill;
    end else begin
      r_kill_pend <= 1'b0;
    end
  end

  // Sticky error on a response with nothing outstanding or a grant with nothing requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (((r_state == IDLE) && m_rvalid) || (m_gnt && !w_m_req)) begin
      r_err <= 1'b1;
    end
  end

  // Outputs are forced quiet while reset is asserted, whatever the inputs do.
  assign i_gnt    = reset_n & w_i_gnt;
  assign d_gnt    = reset_n & w_d_gnt;
  assign i_rvalid = reset_n & w_i_rvalid;
  assign d_rvalid = reset_n & w_d_rvalid;
  assign i_rdata  = (reset_n && w_i_rvalid) ? m_rdata : '0;
  assign d_rdata  = (reset_n && w_d_rvalid) ? m_rdata : '0;
  assign m_req    = reset_n & w_m_req;
  assign m_we     = reset_n & w_m_we;
  assign m_addr   = reset_n ? w_m_addr  : '0;
  assign m_wdata  = reset_n ? w_m_wdata : '0;
  assign m_be     = reset_n ? w_m_be    : '0;
  assign err      = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Latency: inputs change 1ns after the rising edge, outputs are compared on the falling edge.
// Backpressure: the bench memory grants and responds randomly in the random phase.
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic i_req, i_kill, i_gnt, i_rvalid;
  logic [XLEN-1:0] i_addr, i_rdata;
  logic d_req, d_we, d_gnt, d_rvalid;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0] d_be, m_be;
  logic m_req, m_we, m_gnt, m_rvalid, err;
  logic [XLEN-1:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: which requester owns the access in flight (0 none, 1 fetch, 2 data),
  // whether that fetch was flushed, how many arbitrations fetch has lost in a row, sticky error.
  int outst   = 0;
  bit killed  = 0;
  int losses  = 0;
  bit m_err   = 0;
  bit auto_mem = 0;

  // Snapshot of the DUT outputs taken at the last compare point.
  logic ob_ig, ob_dg, ob_irv, ob_drv, ob_mreq, ob_mwe, ob_err;
  logic [XLEN-1:0] ob_ird, ob_maddr, ob_mwdata;

  // One clock: optionally drive memory, compare every output to the model, advance the model.
  task automatic step();
    bit fetch_wins, sel_i, sel_d, e_mreq, e_ig, e_dg, e_irv, e_drv;
    logic [XLEN-1:0] e_addr, e_wd;
    logic [3:0] e_be;
    int prev;
    fetch_wins = i_req && ((losses == SMAX) || !d_req);
    sel_i  = reset_n && (outst == 0) && fetch_wins;
    sel_d  = reset_n && (outst == 0) && d_req && !fetch_wins;
    e_mreq = sel_i || sel_d;
    if (auto_mem) begin
      m_gnt    = e_mreq && ($urandom_range(3) != 0);
      m_rvalid = (outst != 0) && ($urandom_range(1) == 1);
      m_rdata  = $urandom;
    end
    e_ig   = sel_i && m_gnt;
    e_dg   = sel_d && m_gnt;
    e_irv  = reset_n && (outst == 1) && m_rvalid && !killed && !i_kill;
    e_drv  = reset_n && (outst == 2) && m_rvalid;
    e_addr = sel_i ? i_addr : (sel_d ? d_addr : '0);
    e_wd   = sel_d ? d_wdata : '0;
    e_be   = sel_i ? 4'hF : (sel_d ? d_be : 4'h0);

    @(negedge clk);
    ob_ig = i_gnt;  ob_dg = d_gnt;  ob_irv = i_rvalid;  ob_drv = d_rvalid;
    ob_ird = i_rdata;  ob_mreq = m_req;  ob_mwe = m_we;  ob_maddr = m_addr;
    ob_mwdata = m_wdata;  ob_err = err;
    check("m_req",    m_req,    e_mreq);
    check("m_we",     m_we,     sel_d && d_we);
    check("m_addr",   m_addr,   e_addr);
    check("m_wdata",  m_wdata,  e_wd);
    check("m_be",     m_be,     e_be);
    check("i_gnt",    i_gnt,    e_ig);
    check("d_gnt",    d_gnt,    e_dg);
    check("i_rvalid", i_rvalid, e_irv);
    check("i_rdata",  i_rdata,  e_irv ? m_rdata : '0);
    check("d_rvalid", d_rvalid, e_drv);
    check("d_rdata",  d_rdata,  e_drv ? m_rdata : '0);
    check("err",      err,      reset_n ? m_err : 1'b0);
    check("starve",   dut.u_starve.r_cnt, reset_n ? losses : 0);

    if (!reset_n) begin
      outst = 0; killed = 0; losses = 0; m_err = 0;
    end else begin
      prev = outst;
      if ((prev == 0 && m_rvalid) || (m_gnt && !e_mreq)) m_err = 1;
      if (prev == 0) begin
        if (e_ig) begin
          outst = 1; losses = 0;
        end else if (e_dg) begin
          outst = 2;
          if (i_req && losses < SMAX) losses++;
        end
      end else if (m_rvalid) begin
        outst = 0; killed = 0;
      end else if (prev == 1) begin
        killed = killed | i_kill;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = 0; i_addr = '0; i_kill = 0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;

    // Reset with busy inputs: all outputs must stay quiet.
    i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
    step(); step();
    i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
    reset_n = 1'b1;
    step();
    check("rst_err", ob_err, 1'b0);

    // Single fetch, response two cycles after the grant.
    i_req = 1; i_addr = 32'h0; m_gnt = 1;
    step();
    check("f1_gnt", ob_ig, 1'b1);
    i_req = 0; m_gnt = 0;
    step();
    m_rvalid = 1; m_rdata = 32'h0050_0113;
    step();
    check("f1_rvalid", ob_irv, 1'b1);
    check("f1_rdata", ob_ird, 32'h0050_0113);
    check("f1_drv", ob_drv, 1'b0);
    m_rvalid = 0;
    step();
    check("f1_once", ob_irv, 1'b0);

    // Simultaneous fetch and store: data first, fetch once the store is acknowledged.
    i_req = 1; i_addr = 32'h10;
    d_req = 1; d_we = 1; d_addr = 32'd100; d_wdata = 32'd25; d_be = 4'hF; m_gnt = 1;
    step();
    check("sim_dgnt", ob_dg, 1'b1);
    check("sim_ignt", ob_ig, 1'b0);
    check("sim_we", ob_mwe, 1'b1);
    check("sim_addr", ob_maddr, 32'd100);
    check("sim_wdata", ob_mwdata, 32'd25);
    d_req = 0; m_gnt = 0; m_rvalid = 1;
    step();
    check("sim_ack", ob_drv, 1'b1);
    m_rvalid = 0; m_gnt = 1;
    step();
    check("sim_fetch", ob_ig, 1'b1);
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h1111_2222;
    step();
    m_rvalid = 0;

    // Starvation: continuous data traffic, fetch must win the fifth arbitration.
    i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF;
    for (int k = 0; k < 5; k++) begin
      m_gnt = 1;
      step();
      check("stv_dgnt", ob_dg, (k < 4));
      check("stv_ignt", ob_ig, (k == 4));
      m_gnt = 0;
      if (k == 4) begin i_req = 0; d_req = 0; end
      m_rvalid = 1; m_rdata = $urandom;
      step();
      m_rvalid = 0;
    end
    check("stv_clr", dut.u_starve.r_cnt, 0);

    // Flush in WAIT_I, then a normal fetch from 0x40, then a flush coincident with the response.
    i_req = 1; i_addr = 32'h80; m_gnt = 1;
    step();
    i_req = 0; m_gnt = 0; i_kill = 1;
    step();
    i_kill = 0; m_rvalid = 1; m_rdata = 32'hBAD0_BAD0;
    step();
    check("kill_drop", ob_irv, 1'b0);
    m_rvalid = 0; i_req = 1; i_addr = 32'h40; m_gnt = 1;
    step();
    check("kill_next_gnt", ob_ig, 1'b1);
    check("kill_next_addr", ob_maddr, 32'h40);
    i_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h0000_1234;
    step();
    check("kill_next_rv", ob_irv, 1'b1);
    check("kill_next_rd", ob_ird, 32'h0000_1234);
    i_req = 1; i_addr = 32'h44; m_gnt = 1; m_rvalid = 0;
    step();
    i_req = 0; m_gnt = 0; i_kill = 1; m_rvalid = 1;
    step();
    check("kill_same", ob_irv, 1'b0);
    i_kill = 0; m_rvalid = 0;

    // Backpressure: memory withholds the grant for three cycles.
    i_req = 1; i_addr = 32'h4C;
    d_req = 1; d_we = 0; d_addr = 32'h200; d_be = 4'h3; m_gnt = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_mreq", ob_mreq, 1'b1);
      check("bp_addr", ob_maddr, 32'h200);
      check("bp_dgnt", ob_dg, 1'b0);
    end
    m_gnt = 1;
    step();
    check("bp_gnt", ob_dg, 1'b1);
    d_req = 0; m_gnt = 0; m_rvalid = 1;
    step();
    m_rvalid = 0; m_gnt = 1;
    step();
    check("bp_fetch", ob_ig, 1'b1);
    i_req = 0; m_gnt = 0; m_rvalid = 1;
    step();
    m_rvalid = 0;

    // Random traffic with random memory timing and random flushes.
    auto_mem = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!i_req && $urandom_range(2) == 0) begin
        i_req = 1; i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(2) == 0) begin
        d_req = 1; d_we = ($urandom_range(1) == 1);
        d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom_range(15));
      end
      i_kill = ($urandom_range(7) == 0);
      step();
      if (ob_ig) i_req = 0;
      if (ob_dg) d_req = 0;
    end
    auto_mem = 0;
    i_req = 0; d_req = 0; i_kill = 0; m_gnt = 0; m_rvalid = 0;
    for (int c = 0; c < 4 && outst != 0; c++) begin
      m_rvalid = 1;
      step();
      m_rvalid = 0;
    end
    check("rnd_drained", outst, 0);

    // Reset while a load is outstanding; the memory answers after release.
    d_req = 1; d_we = 0; d_addr = 32'h44; d_be = 4'hF; m_gnt = 1;
    step();
    check("mid_dgnt", ob_dg, 1'b1);
    d_req = 0; m_gnt = 0;
    step();
    reset_n = 1'b0;
    i_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1; m_rdata = 32'hDEAD_BEEF;
    step();
    check("mid_rst_drv", ob_drv, 1'b0);
    check("mid_rst_mreq", ob_mreq, 1'b0);
    i_req = 0; d_req = 0; m_gnt = 0; m_rvalid = 0;
    step();
    reset_n = 1'b1; m_rvalid = 1;
    step();
    check("late_drv", ob_drv, 1'b0);
    m_rvalid = 0;
    step();
    check("late_err", ob_err, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
